spi_master_param: RTL and testbench
===================================

// Module: spi_master_param
// PURPOSE
//  Parametrised full-duplex SPI master: serialises a DATA_W-bit word on spi_data (MOSI)
//  and captures spi_miso into dataout, with selectable CPOL/CPHA, bit order and SCLK divider.
//  Start/busy/done handshake to the local controller; drives one slave select (spi_cs_l).
// PARAMETERS
//  DATA_W     16  word length in bits (>=2)
//  CLK_DIV    4   clk cycles per SCLK half-period (>=1)
//  CPOL       0   SCLK idle level
//  CPHA       0   0: sample on leading edge, shift on trailing; 1: shift leading, sample trailing
//  MSB_FIRST  1   1: bit DATA_W-1 first; 0: bit 0 first
//  CNT_W      $clog2(DATA_W+1)  width of counter output (localparam)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  start      in   1       request transfer; accepted only in IDLE
//  datain     in   DATA_W  TX word, latched on start acceptance
//  spi_miso   in   1       serial data from slave
//  spi_cs_l   out  1       slave select, active low
//  spi_sclk   out  1       serial clock
//  spi_data   out  1       serial data to slave (MOSI)
//  dataout    out  DATA_W  last RX word, valid from done pulse until next done
//  busy       out  1       high from cycle after acceptance through LAG
//  done       out  1       one-cycle pulse at end of transfer
//  counter    out  CNT_W   bits sampled in current/last transfer
// BEHAVIOUR
//  Reset (any state, mid-transfer included): next edge -> IDLE, spi_cs_l=1, spi_sclk=CPOL,
//   spi_data=0, busy=0, done=0, dataout=0, counter=0, divider=0, shift regs cleared.
//  Divider: counts 0..CLK_DIV-1 in LEAD/XFER/LAG, tick at CLK_DIV-1, restarts at state entry.
//  FSM:
//   IDLE: start=1 -> latch datain, counter=0, busy=1, spi_cs_l=0, spi_data=first bit -> LEAD.
//   LEAD: one half-period with SCLK at CPOL; on tick -> XFER.
//   XFER: each tick toggles spi_sclk; exactly 2*DATA_W edges; after edge 2*DATA_W -> LAG.
//   LAG: one half-period, SCLK at CPOL, spi_cs_l still 0; on tick -> DONE, busy=0.
//   DONE: one cycle: spi_cs_l=1, done=1, dataout=RX shift reg, spi_data=0 -> IDLE.
//  Edges: odd-numbered = leading, even = trailing.
//   CPHA=0: sample spi_miso on leading edges; advance spi_data on trailing edges 2..2*DATA_W-2.
//   CPHA=1: advance spi_data on leading edges 3..2*DATA_W-1; sample on trailing edges.
//   Sampling: spi_miso registered on the same clk edge the sclk register toggles.
//   counter increments on each sample, holds DATA_W after transfer until next acceptance.
//   RX bits assembled in the same order as MSB_FIRST.
//  Latency: start sampled at edge k -> spi_cs_l low from k+1 -> done high after edge
//   k+1+CLK_DIV*(2*DATA_W+2), for exactly one cycle.
//  start while busy or in DONE: ignored, no queueing; datain changes while busy: no effect.
//  Minimum spi_cs_l high time between transfers: 2 clk cycles (DONE + IDLE).
// TESTING
//  T1 DATA_W=16,CLK_DIV=2,mode0, MISO looped to MOSI, datain=16'hACF1 -> 16 SCLK pulses,
//   MOSI MSB-first 1010_1100_1111_0001, dataout=16'hACF1, done at start+69, counter=16.
//  T2 CPOL=1,CPHA=1, slave model returns 16'h5A3C, datain=16'hFFFF -> SCLK idles 1,
//   dataout=16'h5A3C, MOSI stable at every trailing (rising) edge.
//  T3 MSB_FIRST=0, datain=16'h0001 -> MOSI 1 on first sample edge only; loopback 16'h0001.
//  T4 start pulsed again at cycles 10 and 40 of a transfer -> ignored, one done only.
//  T5 reset at cycle 20 of transfer -> next cycle all outputs at reset values; new start
//   then completes normally with correct data.
//  T6 start held high continuously -> back-to-back transfers, spi_cs_l high 2 cycles between.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with a single slave select.
// Supports CPOL/CPHA modes, selectable bit order and an integer SCLK divider.
module spi_master_param #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] datain,
  input  logic              spi_miso,
  output logic              spi_cs_l,
  output logic              spi_sclk,
  output logic              spi_data,
  output logic [DATA_W-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  counter
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, LAG, DONE} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_l_q, cs_l_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   dataout_q, dataout_d;
  logic [CNT_W-1:0]    counter_q, counter_d;

  logic                tick;
  logic [EDGE_W-1:0]   edge_n;
  logic                leading;

  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign edge_n  = edge_q + EDGE_W'(1);
  assign leading = edge_n[0];

  // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_l_d    = cs_l_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dataout_d = dataout_q;
    counter_d = counter_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_d      = datain;
          mosi_d    = MSB_FIRST ? datain[DATA_W-1] : datain[0];
          counter_d = '0;
          edge_d    = '0;
          busy_d    = 1'b1;
          cs_l_d    = 1'b0;
          state_d   = LEAD;
        end
      end
      LEAD: begin
        if (tick) state_d = XFER;
        else      div_d   = div_q + DIV_W'(1);
      end
      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_n;
          // Sample on leading edges in mode CPHA=0, trailing edges in CPHA=1.
          if (leading ^ CPHA) begin
            rx_d      = MSB_FIRST ? {rx_q[DATA_W-2:0], spi_miso} : {spi_miso, rx_q[DATA_W-1:1]};
            counter_d = counter_q + CNT_W'(1);
          end else if ((!CPHA && edge_n <= EDGE_W'(2 * DATA_W - 2)) ||
                       (CPHA && edge_n >= EDGE_W'(3))) begin
            tx_d   = MSB_FIRST ? (tx_q << 1) : (tx_q >> 1);
            mosi_d = MSB_FIRST ? tx_q[DATA_W-2] : tx_q[1];
          end
          if (edge_n == EDGE_W'(2 * DATA_W)) state_d = LAG;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LAG: begin
        if (tick) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          cs_l_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          dataout_d = rx_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset also clears the data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      cs_l_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dataout_q <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_l_q    <= cs_l_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dataout_q <= dataout_d;
      counter_q <= counter_d;
    end
  end

  assign spi_cs_l = cs_l_q;
  assign spi_sclk = sclk_q;
  assign spi_data = mosi_q;
  assign dataout  = dataout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign counter  = counter_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: mode 0 loopback, mode 3 with a slave model,
// LSB-first loopback, ignored starts, mid-transfer reset and back-to-back transfers.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  // u0: mode 0, MSB first, loopback
  logic        start0, cs0, sclk0, mosi0, busy0, done0, miso0;
  logic [15:0] din0, dout0;
  logic [4:0]  cnt0;
  assign miso0 = mosi0;

  // u1: mode 3 (CPOL=1, CPHA=1), slave model on MISO
  logic        start1, cs1, sclk1, mosi1, busy1, done1, miso1;
  logic [15:0] din1, dout1;
  logic [4:0]  cnt1;

  // u2: mode 0, LSB first, loopback
  logic        start2, cs2, sclk2, mosi2, busy2, done2, miso2;
  logic [15:0] din2, dout2;
  logic [4:0]  cnt2;
  assign miso2 = mosi2;

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .datain(din0), .spi_miso(miso0),
    .spi_cs_l(cs0), .spi_sclk(sclk0), .spi_data(mosi0), .dataout(dout0),
    .busy(busy0), .done(done0), .counter(cnt0));

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .datain(din1), .spi_miso(miso1),
    .spi_cs_l(cs1), .spi_sclk(sclk1), .spi_data(mosi1), .dataout(dout1),
    .busy(busy1), .done(done1), .counter(cnt1));

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start2), .datain(din2), .spi_miso(miso2),
    .spi_cs_l(cs2), .spi_sclk(sclk2), .spi_data(mosi2), .dataout(dout2),
    .busy(busy2), .done(done2), .counter(cnt2));

  // Mode-3 slave: presents the next MSB-first bit on every falling (leading) SCLK edge.
  logic [15:0] slave_word = 16'h5A3C;
  int          sidx = -1;
  initial miso1 = 1'b0;
  always @(negedge cs1) sidx = 15;
  always @(negedge sclk1) begin
    if (cs1 === 1'b0 && sidx >= 0) begin
      miso1 = slave_word[sidx];
      sidx--;
    end
  end

  // Runs one u0 transfer from the post-edge phase; optional extra start pulses at pa/pb.
  task automatic run0(input logic [15:0] din, input int ncyc, input int pa, input int pb,
                      output int first_done, output int ndone, output int npulse,
                      output logic [15:0] mword, output logic cs_e, output logic busy_e);
    logic prev;
    first_done = -1; ndone = 0; npulse = 0; mword = '0; cs_e = 1'b1; busy_e = 1'b0;
    din0 = din; start0 = 1'b1; prev = sclk0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin cs_e = cs0; busy_e = busy0; din0 = ~din; end
      start0 = (n == pa || n == pb);
      if (n == pa || n == pb) din0 = 16'hFFFF;
      if (!prev && sclk0) begin npulse++; mword = {mword[14:0], mosi0}; end
      prev = sclk0;
      if (done0) begin ndone++; if (first_done < 0) first_done = n; end
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk0 got %b want 0", sclk0); end
    checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL reset_sclk1 got %b want 1", sclk1); end
    checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi0); end
    checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {busy0, done0}); end
    checks++; if (dout0 !== 16'h0) begin errors++; $display("FAIL reset_dataout got %h want 0000", dout0); end
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL reset_counter got %0d want 0", cnt0); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0_loopback();
    int fd, nd, np;
    logic [15:0] mw;
    logic ce, be;
    run0(16'hACF1, 75, 0, 0, fd, nd, np, mw, ce, be);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL t1_cs_low got %b want 0", ce); end
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", be); end
    checks++; if (fd != 69) begin errors++; $display("FAIL t1_done_cycle got %0d want 69", fd); end
    checks++; if (nd != 1) begin errors++; $display("FAIL t1_done_count got %0d want 1", nd); end
    checks++; if (np != 16) begin errors++; $display("FAIL t1_sclk_pulses got %0d want 16", np); end
    checks++; if (mw !== 16'hACF1) begin errors++; $display("FAIL t1_mosi got %h want acf1", mw); end
    checks++; if (dout0 !== 16'hACF1) begin errors++; $display("FAIL t1_dataout got %h want acf1", dout0); end
    checks++; if (cnt0 !== 5'd16) begin errors++; $display("FAIL t1_counter got %0d want 16", cnt0); end
    checks++; if ({cs0, busy0} !== 2'b10) begin errors++; $display("FAIL t1_idle got %b want 10", {cs0, busy0}); end
  endtask

  task automatic test_mode3_slave();
    int fd = -1, rises = 0, bad = 0;
    logic prev;
    checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL t2_sclk_idle got %b want 1", sclk1); end
    din1 = 16'hFFFF; start1 = 1'b1; prev = sclk1;
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (!prev && sclk1) begin rises++; if (mosi1 !== 1'b1) bad++; end
      prev = sclk1;
      if (done1 && fd < 0) fd = n;
    end
    checks++; if (rises != 16) begin errors++; $display("FAIL t2_rising_edges got %0d want 16", rises); end
    checks++; if (bad != 0) begin errors++; $display("FAIL t2_mosi_stable got %0d bad want 0", bad); end
    checks++; if (fd != 69) begin errors++; $display("FAIL t2_done_cycle got %0d want 69", fd); end
    checks++; if (dout1 !== 16'h5A3C) begin errors++; $display("FAIL t2_dataout got %h want 5a3c", dout1); end
    checks++; if (cnt1 !== 5'd16) begin errors++; $display("FAIL t2_counter got %0d want 16", cnt1); end
    checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL t2_sclk_end got %b want 1", sclk1); end
  endtask

  task automatic test_lsb_first();
    int ones = 0, rises = 0;
    logic first_bit = 1'b0;
    logic prev;
    logic [15:0] mw = '0;
    din2 = 16'h0001; start2 = 1'b1; prev = sclk2;
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (!prev && sclk2) begin
        rises++;
        if (rises == 1) first_bit = mosi2;
        if (mosi2) ones++;
        mw = {mosi2, mw[15:1]};
      end
      prev = sclk2;
    end
    checks++; if (first_bit !== 1'b1) begin errors++; $display("FAIL t3_first_bit got %b want 1", first_bit); end
    checks++; if (ones != 1) begin errors++; $display("FAIL t3_ones got %0d want 1", ones); end
    checks++; if (mw !== 16'h0001) begin errors++; $display("FAIL t3_mosi got %h want 0001", mw); end
    checks++; if (dout2 !== 16'h0001) begin errors++; $display("FAIL t3_dataout got %h want 0001", dout2); end
  endtask

  task automatic test_ignore_start();
    int fd, nd, np;
    logic [15:0] mw;
    logic ce, be;
    run0(16'h3C5A, 150, 10, 40, fd, nd, np, mw, ce, be);
    checks++; if (nd != 1) begin errors++; $display("FAIL t4_done_count got %0d want 1", nd); end
    checks++; if (fd != 69) begin errors++; $display("FAIL t4_done_cycle got %0d want 69", fd); end
    checks++; if (dout0 !== 16'h3C5A) begin errors++; $display("FAIL t4_dataout got %h want 3c5a", dout0); end
    checks++; if (mw !== 16'h3C5A) begin errors++; $display("FAIL t4_mosi got %h want 3c5a", mw); end
    checks++; if ({cs0, busy0} !== 2'b10) begin errors++; $display("FAIL t4_idle got %b want 10", {cs0, busy0}); end
  endtask

  task automatic test_reset_mid();
    int fd, nd, np;
    logic [15:0] mw;
    logic ce, be;
    din0 = 16'h1111; start0 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      if (n == 19) reset = 1'b1;
    end
    checks++; if ({cs0, sclk0, mosi0} !== 3'b100) begin errors++; $display("FAIL t5_pins got %b want 100", {cs0, sclk0, mosi0}); end
    checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL t5_busy_done got %b want 00", {busy0, done0}); end
    checks++; if (dout0 !== 16'h0) begin errors++; $display("FAIL t5_dataout got %h want 0000", dout0); end
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL t5_counter got %0d want 0", cnt0); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run0(16'hBEEF, 75, 0, 0, fd, nd, np, mw, ce, be);
    checks++; if (fd != 69) begin errors++; $display("FAIL t5_done_cycle got %0d want 69", fd); end
    checks++; if (dout0 !== 16'hBEEF) begin errors++; $display("FAIL t5_dataout_after got %h want beef", dout0); end
  endtask

  task automatic test_back_to_back();
    int d[3] = '{-1, -1, -1};
    int nd = 0, cs_high = 0;
    din0 = 16'hACF1; start0 = 1'b1;
    for (int n = 1; n <= 215; n++) begin
      @(posedge clk); #1;
      if (done0) begin if (nd < 3) d[nd] = n; nd++; end
      if (d[0] > 0 && n >= d[0] && n <= d[0] + 4 && cs0) cs_high++;
    end
    start0 = 1'b0;
    checks++; if (nd != 3) begin errors++; $display("FAIL t6_done_count got %0d want 3", nd); end
    checks++; if (d[0] != 69) begin errors++; $display("FAIL t6_first_done got %0d want 69", d[0]); end
    checks++; if (d[1] != 139) begin errors++; $display("FAIL t6_second_done got %0d want 139", d[1]); end
    checks++; if (cs_high != 2) begin errors++; $display("FAIL t6_cs_high got %0d want 2", cs_high); end
    checks++; if (dout0 !== 16'hACF1) begin errors++; $display("FAIL t6_dataout got %h want acf1", dout0); end
    repeat (80) @(posedge clk);
    #1;
    checks++; if ({cs0, busy0} !== 2'b10) begin errors++; $display("FAIL t6_drain got %b want 10", {cs0, busy0}); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_lsb_first();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
